// File: rtl/pl_mem_wb.sv
// pl_mem_wb: memory-access / writeback stage with an in-order store buffer.
// Define PL_MEM_WB_LD_FWD_EN to enable store-to-load forwarding.
module pl_mem_wb #(
    parameter int NUM_DOMAINS = 1,
    parameter int SB_DEPTH    = 4,
    parameter int ADDR_WID    = 16,
    localparam int DW = NUM_DOMAINS * 8,
    localparam int PW = $clog2(SB_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [0:6]          EX_reg,
    input  logic [DW-1:0]       operation_result,
    input  logic [ADDR_WID-1:0] data_wr_addr,
    input  logic [ADDR_WID-1:0] data_rd_addr,
    input  logic [2:0]          destination_reg_addr,
    output logic                stall_out,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_WID-1:0] dmem_addr,
    output logic [DW-1:0]       dmem_wdata,
    input  logic                dmem_ack,
    input  logic [DW-1:0]       dmem_rdata,
    output logic                rf_wr_en,
    output logic [2:0]          rf_wr_addr,
    output logic [DW-1:0]       rf_wr_data,
    output logic [CW-1:0]       sb_count,
    output logic                sb_empty
);

    typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} state_t;

    state_t              state_q, state_d;
    logic                ld_pending, ld_pend_d;
    logic [ADDR_WID-1:0] ld_addr_q, ld_addr_d;
    logic [2:0]          ld_dest_q, ld_dest_d;
    logic                req_d, we_d;
    logic [ADDR_WID-1:0] addr_d;
    logic [DW-1:0]       wdata_d;
    logic                rf_en_d;
    logic [2:0]          rf_addr_d;
    logic [DW-1:0]       rf_data_d;

    logic [ADDR_WID-1:0] sb_addr [SB_DEPTH];
    logic [DW-1:0]       sb_data [SB_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;

    logic valid, is_st, is_ld, is_alu;
    logic acc, push, pop, full, empty;
    logic ld_new, ld_go;
    logic unused_ex;

    assign unused_ex = ^{EX_reg[2], EX_reg[5], EX_reg[6]};

    assign valid  = !EX_reg[3];
    assign is_st  = valid && EX_reg[0];
    assign is_ld  = valid && !EX_reg[0] && EX_reg[4];
    assign is_alu = valid && !EX_reg[0] && !EX_reg[4] && EX_reg[1];

    assign full      = (count == CW'(SB_DEPTH));
    assign empty     = (count == '0);
    assign stall_out = ld_pending || (full && is_st);
    assign acc       = !stall_out;
    assign push      = acc && is_st;
    assign sb_count  = count;
    assign sb_empty  = empty;

`ifdef PL_MEM_WB_LD_FWD_EN
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count && sb_addr[idx] == data_rd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[idx];
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        ld_pend_d = ld_pending;
        ld_addr_d = ld_addr_q;
        ld_dest_d = ld_dest_q;
        req_d     = dmem_req;
        we_d      = dmem_we;
        addr_d    = dmem_addr;
        wdata_d   = dmem_wdata;
        rf_en_d   = 1'b0;
        rf_addr_d = rf_wr_addr;
        rf_data_d = rf_wr_data;
        pop       = 1'b0;
        ld_new    = 1'b0;

        if (acc && is_alu) begin
            rf_en_d   = 1'b1;
            rf_addr_d = destination_reg_addr;
            rf_data_d = operation_result;
        end

        if (acc && is_ld) begin
`ifdef PL_MEM_WB_LD_FWD_EN
            if (fwd_hit) begin
                rf_en_d   = 1'b1;
                rf_addr_d = destination_reg_addr;
                rf_data_d = fwd_data;
            end else begin
                ld_new = 1'b1;
            end
`else
            ld_new = 1'b1;
`endif
        end

        if (ld_new) begin
            ld_pend_d = 1'b1;
            ld_addr_d = data_rd_addr;
            ld_dest_d = destination_reg_addr;
        end

        // A miss never aliases a buffered store, so it may bypass drains.
`ifdef PL_MEM_WB_LD_FWD_EN
        ld_go = ld_pending || ld_new;
`else
        ld_go = (ld_pending || ld_new) && empty;
`endif

        unique case (state_q)
            IDLE: begin
                if (ld_go) begin
                    state_d = LD_WAIT;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = ld_addr_d;
                end else if (!empty) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = sb_addr[rd_ptr];
                    wdata_d = sb_data[rd_ptr];
                end
            end
            LD_WAIT: begin
                if (dmem_ack) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    ld_pend_d = 1'b0;
                    rf_en_d   = 1'b1;
                    rf_addr_d = ld_dest_q;
                    rf_data_d = dmem_rdata;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    pop     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ld_pending <= 1'b0;
            ld_addr_q  <= '0;
            ld_dest_q  <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state_q    <= state_d;
            ld_pending <= ld_pend_d;
            ld_addr_q  <= ld_addr_d;
            ld_dest_q  <= ld_dest_d;
            dmem_req   <= req_d;
            dmem_we    <= we_d;
            dmem_addr  <= addr_d;
            dmem_wdata <= wdata_d;
            rf_wr_en   <= rf_en_d;
            rf_wr_addr <= rf_addr_d;
            rf_wr_data <= rf_data_d;
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            count      <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[wr_ptr] <= data_wr_addr;
            sb_data[wr_ptr] <= operation_result;
        end
    end

endmodule
